// File: rtl/pow_pkg.sv
// Shared constants and helpers for the 5th-power pipeline and its consumers.
package pow_pkg;

   localparam int unsigned POW_W               = 8;
   localparam int unsigned POW_FIFO_DEPTH_LOG2 = 2;

   // Ceiling log2, for sizing counters at elaboration time.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = 1;
      while (v < value) begin
         v   = v << 1;
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/pow_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous show-ahead read.
module pow_fifo_mem
   import pow_pkg::*;
#(
   parameter int unsigned w          = POW_W,
   parameter int unsigned depth_log2 = POW_FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [depth_log2-1:0] wr_ptr,
   input  logic [w-1:0]          wr_data,
   input  logic [depth_log2-1:0] rd_ptr,
   output logic [w-1:0]          rd_data
);

   localparam int unsigned DEPTH = 1 << depth_log2;

   logic [w-1:0] mem [DEPTH];

   // Contents are deliberately not reset; validity is tracked by the occupancy count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/pow_res_fifo.sv
// Buffers final-stage pipeline results for a slower valid/ready sink, with sticky overflow.
module pow_res_fifo
   import pow_pkg::*;
#(
   parameter int unsigned w          = POW_W,
   parameter int unsigned depth_log2 = POW_FIFO_DEPTH_LOG2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  in_vld,
   input  logic [w-1:0]          in_data,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [w-1:0]          out_data,
   output logic [depth_log2:0]   count,
   output logic                  ovf,
   input  logic                  ovf_clr
);

   localparam int unsigned DEPTH = 1 << depth_log2;
   localparam int unsigned CW    = clog2(DEPTH + 1);

   logic [depth_log2-1:0] wr_ptr;
   logic [depth_log2-1:0] rd_ptr;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  accept;
   logic                  drop;

   assign push    = clk_en & in_vld;
   assign out_vld = (count != '0);
   assign pop     = out_vld & out_rdy;
   assign full    = (count == CW'(DEPTH));
   // A pop in the same cycle frees the slot the push needs.
   assign accept  = push & (~full | pop);
   assign drop    = push & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + depth_log2'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + depth_log2'(1);
         end
         if (accept && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !accept) begin
            count <= count - CW'(1);
         end
         // Set takes priority so a drop coinciding with a clear is not lost.
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

   pow_fifo_mem #(
      .w          (w),
      .depth_log2 (depth_log2)
   ) u_mem (
      .clk     (clk),
      .wr_en   (accept),
      .wr_ptr  (wr_ptr),
      .wr_data (in_data),
      .rd_ptr  (rd_ptr),
      .rd_data (out_data)
   );

endmodule

// File: tb/tb_pow_res_fifo.sv
// Self-checking bench for pow_res_fifo: vector table for count/valid/ovf, data scoreboard.
module tb_pow_res_fifo;

   logic       clk;
   logic       rst;
   logic       clk_en;
   logic       in_vld;
   logic [7:0] in_data;
   logic       out_vld;
   logic       out_rdy;
   logic [7:0] out_data;
   logic [2:0] count;
   logic       ovf;
   logic       ovf_clr;

   int total;
   int bad;
   int mc;
   logic [7:0] sb_q [$];

   typedef struct {
      logic       ce;
      logic       iv;
      logic [7:0] d;
      logic       rdy;
      logic       clr;
      int         cnt;
      logic       vld;
      logic       ov;
   } vec_t;

   vec_t tbl [$];

   pow_res_fifo #(.w(8), .depth_log2(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .in_vld   (in_vld),
      .in_data  (in_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy),
      .out_data (out_data),
      .count    (count),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      total = total + 1;
      if (act != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic ce, input logic iv, input logic [7:0] d, input logic rdy,
                      input logic clr, input int cnt, input logic vld, input logic ov);
      vec_t v;
      v.ce = ce; v.iv = iv; v.d = d; v.rdy = rdy; v.clr = clr;
      v.cnt = cnt; v.vld = vld; v.ov = ov;
      tbl.push_back(v);
   endtask

   // Drive one cycle (called just after an edge); scoreboard follows the FIFO rules.
   task automatic cycle(input logic ce, input logic iv, input logic [7:0] d,
                        input logic rdy, input logic clr);
      logic pop_m;
      logic acc_m;
      logic [7:0] exp_d;
      clk_en = ce; in_vld = iv; in_data = d; out_rdy = rdy; ovf_clr = clr;
      #1;
      chk("pre_edge_vld", int'(out_vld), int'(mc != 0));
      pop_m = (mc != 0) && rdy;
      if (pop_m) begin
         if (sb_q.size() == 0) begin
            chk("scoreboard_underflow", 1, 0);
         end else begin
            exp_d = sb_q.pop_front();
            chk("out_data", int'(out_data), int'(exp_d));
         end
      end
      acc_m = ce && iv && ((mc < 4) || pop_m);
      if (acc_m) sb_q.push_back(d);
      if (acc_m && !pop_m) mc = mc + 1;
      else if (pop_m && !acc_m) mc = mc - 1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0; bad = 0; mc = 0;
      rst = 1'b1; clk_en = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; ovf_clr = 1'b0;

      //   ce  iv  d    rdy clr  cnt vld ovf
      add(1, 0, 0,   0, 0,   0, 0, 0);   // idle after reset
      add(1, 1, 243, 0, 0,   1, 1, 0);   // single result 3^5
      add(1, 0, 0,   1, 0,   0, 0, 0);   // consume it
      add(1, 1, 32,  0, 0,   1, 1, 0);   // fill
      add(1, 1, 243, 0, 0,   2, 1, 0);
      add(1, 1, 0,   0, 0,   3, 1, 0);
      add(1, 1, 1,   0, 0,   4, 1, 0);   // full
      add(1, 1, 7,   0, 0,   4, 1, 1);   // overflow drops 7
      add(1, 0, 0,   0, 1,   4, 1, 0);   // clear ovf
      add(1, 1, 8,   0, 1,   4, 1, 1);   // overflow + clear: set wins
      add(1, 0, 0,   0, 1,   4, 1, 0);
      add(1, 1, 99,  1, 0,   4, 1, 0);   // full push+pop
      for (int i = 0; i < 5; i++) add(0, 1, 55, 0, 0, 4, 1, 0);  // gated push
      add(0, 1, 55,  1, 0,   3, 1, 0);   // pops ignore clk_en
      add(0, 1, 55,  1, 0,   2, 1, 0);
      add(0, 1, 55,  1, 0,   1, 1, 0);
      add(0, 1, 55,  1, 0,   0, 0, 0);   // 99 emerges last
      add(1, 1, 5,   1, 0,   1, 1, 0);   // empty: no bypass, no pop
      add(0, 0, 0,   1, 0,   0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_count", int'(count), 0);
      chk("reset_vld", int'(out_vld), 0);
      chk("reset_ovf", int'(ovf), 0);

      foreach (tbl[i]) begin
         cycle(tbl[i].ce, tbl[i].iv, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("row%0d_count", i), int'(count), tbl[i].cnt);
         chk($sformatf("row%0d_vld", i), int'(out_vld), int'(tbl[i].vld));
         chk($sformatf("row%0d_ovf", i), int'(ovf), int'(tbl[i].ov));
      end

      // Asynchronous reset with three entries queued.
      cycle(1, 1, 11, 0, 0);
      cycle(1, 1, 12, 0, 0);
      cycle(1, 1, 13, 0, 0);
      chk("midrst_pre_count", int'(count), 3);
      #2 rst = 1'b1;
      #1;
      chk("midrst_vld_async", int'(out_vld), 0);
      chk("midrst_count_async", int'(count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      mc = 0;

      // Operation resumes cleanly after reset.
      cycle(1, 1, 77, 0, 0);
      chk("post_rst_count", int'(count), 1);
      cycle(0, 0, 0, 1, 0);
      chk("post_rst_drain", int'(count), 0);
      chk("scoreboard_empty", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pow_res_fifo.md
Name: pow_res_fifo

Overview:
- Downstream consumer of the 5th-power pipeline.
- Captures each valid final-stage result (n^5, w bits, valid on the pipeline's last-stage valid bit) on clock-enabled cycles and buffers it in a small FIFO.
- Presents results to a slower sink (display/UART formatter) over a valid/ready handshake.
- Provides occupancy and a sticky overflow flag so lost results are visible.

Parameters:
- w, 8, data width; equals the pipeline's w (final-stage result slice).
- depth_log2, 2, log2 of FIFO depth (default depth 4).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- clk_en  input  1  same enable that advances the upstream pipeline; qualifies capture only.
- in_vld  input  1  final-stage valid from the pipeline.
- in_data  input  w  final-stage result n^5 (already truncated to w bits upstream).
- out_vld  output  1  FIFO non-empty; out_data is valid.
- out_rdy  input  1  sink accepts out_data this cycle.
- out_data  output  w  head-of-FIFO result.
- count  output  depth_log2+1  current occupancy, 0..2^depth_log2.
- ovf  output  1  sticky: a result was dropped because the FIFO was full.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset: pointers = 0, count = 0, out_vld = 0, ovf = 0. out_data is don't-care while out_vld = 0. Storage array is not reset.
- Push request: push = clk_en & in_vld.
  - clk_en gates capture only; pop is independent of clk_en.
- Pop: pop = out_vld & out_rdy.
- Push accepted when count < depth, or when a pop occurs in the same cycle (full + push + pop: both happen, count unchanged).
- Write: data goes to mem[wr_ptr], then wr_ptr increments.
- Read: show-ahead; out_data = mem[rd_ptr] combinationally. rd_ptr increments on pop.
- Pointers are depth_log2 bits and wrap naturally from depth-1 to 0.
- count update:
  - +1 on accepted push without pop.
  - -1 on pop without push.
  - Unchanged on both or neither.
- out_vld = (count != 0). It is derived from registered count, so it is glitch-free.
- Latency: a result pushed at edge k is visible on out_vld/out_data after edge k. There is no same-cycle bypass, even when the FIFO is empty.
- Empty + push + out_rdy = 1: no pop that cycle, since out_vld = 0.
- Overflow: push while full and no pop → data dropped, pointers and count unchanged, ovf <= 1.
- ovf_clr and an overflow event in the same cycle: set wins, ovf stays 1.
- ovf_clr otherwise: ovf <= 0 at the next edge.
- Ordering: strict FIFO; results leave in pipeline order.
- Reset mid-operation: all contents are discarded immediately (asynchronous), out_vld drops without waiting for a clock.

Decomposition:
- Shared package (team pow_pkg):
  - POW_W = 8.
  - POW_FIFO_DEPTH_LOG2 = 2.
  - Function clog2 for count width.
- Sub-module: none required.
  - Storage plus pointers may optionally be factored as pow_fifo_mem (simple dual-port array, sync write, async read).
  - Control (count, ovf, accept logic) stays in pow_res_fifo.
- Target ~150 lines RTL.

Test Plan:
- Reset then idle: rst pulse, no pushes → out_vld=0, count=0, ovf=0. Also assert rst mid-stream with count=3 → out_vld falls asynchronously, count=0.
- Single result: clk_en=1, in_vld=1, in_data=243 (3^5) for one cycle, out_rdy=0 → next cycle out_vld=1, out_data=243, count=1. Then out_rdy=1 for one cycle → count=0, out_vld=0.
- Fill and order: push 32, 243, 0 (4^5 mod 256), 1 with out_rdy=0 → count=4. Then drain with out_rdy=1 → outputs 32, 243, 0, 1 in order, then out_vld=0.
- Overflow: FIFO full (4 entries), push 7 with out_rdy=0 → count stays 4, ovf=1, drained data excludes 7. Pulse ovf_clr → ovf=0 next cycle. Overflow and ovf_clr in the same cycle → ovf=1.
- Full with simultaneous push/pop: count=4, push 99 and out_rdy=1 same cycle → count stays 4, ovf=0, 99 emerges last after 3 older entries.
- clk_en gating: in_vld=1 with clk_en=0 for 5 cycles → no push, count unchanged. Pops with clk_en=0 and out_rdy=1 still drain the FIFO.
